// File: rtl/noc_out_switch.sv
// Two-input packet-locked round-robin switch driving one registered output port.
// 1-cycle in->out latency; in_ready drops to 0 whenever the output register is full and not drained.
module noc_out_switch #(
  parameter int FLIT_W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [1:0]          in_valid,
  input  logic [2*FLIT_W-1:0] in_data,
  input  logic [1:0]          in_last,
  output logic [1:0]          in_ready,
  output logic                out_valid,
  output logic [FLIT_W-1:0]   out_data,
  output logic                out_last,
  output logic                out_src,
  input  logic                out_ready,
  output logic [15:0]         pkt_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0] state;
  logic       owner;
  logic       ptr;
  logic [1:0] grant;
  logic       space;
  logic       xfer;
  logic       sel;
  logic       sel_last;
  logic [FLIT_W-1:0] sel_data;

  // While locked only the packet owner may send; otherwise ptr breaks ties.
  always_comb begin
    grant = 2'b00;
    if (state == LOCKED) begin
      grant[owner] = 1'b1;
    end else if (&in_valid) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = in_valid;
    end
  end

  assign space    = ~out_valid | out_ready;
  assign in_ready = (space && arst) ? grant : 2'b00;
  assign xfer     = |(in_valid & in_ready);
  assign sel      = in_ready[1];
  assign sel_last = in_last[sel];
  assign sel_data = sel ? in_data[2*FLIT_W-1:FLIT_W] : in_data[FLIT_W-1:0];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
      pkt_cnt   <= 16'd0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_src   <= sel;
        // Priority only moves at packet end, so a locked packet never loses its turn.
        if (sel_last) begin
          state   <= IDLE;
          ptr     <= ~sel;
          pkt_cnt <= pkt_cnt + 16'd1;
        end else begin
          state <= LOCKED;
          owner <= sel;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
